// File: rtl/mult_share_sched.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : mult_share_sched (+ ArrayMultiplier_generic)                |
// | Purpose  : round-robin sharing of one ripple array multiplier among    |
// |            NREQ requesters, with registered operands and result.       |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+

module ArrayMultiplier_generic #(
   parameter int M = 8,
   parameter int N = 8
) (
   input  logic [M-1:0]   m_i,
   input  logic [N-1:0]   n_i,
   output logic [M+N-1:0] p_o
);
   logic [M+N-1:0] w_row [0:N];

   assign w_row[0] = '0;

   // One adder row per multiplier bit; the ripple through these rows is what SETTLE covers.
   generate
      for (genvar i = 0; i < N; i++) begin : g_row
         assign w_row[i+1] = w_row[i] + (n_i[i] ? ({{N{1'b0}}, m_i} << i) : '0);
      end
   endgenerate

   assign p_o = w_row[N];
endmodule

module mult_share_sched #(
   parameter  int M      = 8,
   parameter  int N      = 8,
   parameter  int NREQ   = 4,
   parameter  int SETTLE = 2,
   localparam int IDW    = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*M-1:0] req_a,
   input  logic [NREQ*N-1:0] req_x,
   output logic [NREQ-1:0]   req_ready,
   output logic              res_valid,
   output logic [M+N-1:0]    res_p,
   output logic [IDW-1:0]    res_id,
   input  logic              res_ready,
   output logic              busy
);
   localparam int          CW         = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] C_CNT_INIT = CW'(SETTLE - 1);
   localparam logic [IDW:0]  C_NREQ     = (IDW+1)'(NREQ);
   localparam logic [IDW-1:0] C_LAST    = IDW'(NREQ - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t          state_q;
   logic [IDW-1:0]  ptr_q;
   logic [IDW-1:0]  ptr_d;
   logic [M-1:0]    op_a_q;
   logic [N-1:0]    op_x_q;
   logic [IDW-1:0]  tag_q;
   logic [CW-1:0]   cnt_q;
   logic            res_valid_q;
   logic [M+N-1:0]  res_p_q;
   logic [IDW-1:0]  res_id_q;

   logic            w_found;
   logic [IDW-1:0]  w_gnt;
   logic [IDW:0]    w_scan;
   logic [M-1:0]    w_a_sel;
   logic [N-1:0]    w_x_sel;
   logic [M+N-1:0]  w_prod;

   // Scan from ptr upward, wrapping at NREQ; the first valid requester wins.
   always_comb begin
      w_found = 1'b0;
      w_gnt   = '0;
      w_scan  = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_scan = {1'b0, ptr_q} + (IDW+1)'(k);
         if (w_scan >= C_NREQ) begin
            w_scan = w_scan - C_NREQ;
         end
         if (!w_found && req_valid[w_scan[IDW-1:0]]) begin
            w_found = 1'b1;
            w_gnt   = w_scan[IDW-1:0];
         end
      end
   end

   always_comb begin
      ptr_d = (w_gnt == C_LAST) ? '0 : w_gnt + 1'b1;
   end

   assign w_a_sel   = req_a[w_gnt*M +: M];
   assign w_x_sel   = req_x[w_gnt*N +: N];
   assign req_ready = (state_q == S_IDLE && w_found) ? (NREQ'(1) << w_gnt) : '0;

   ArrayMultiplier_generic #(
      .M (M),
      .N (N)
   ) u_array (
      .m_i (op_a_q),
      .n_i (op_x_q),
      .p_o (w_prod)
   );

   // Operand registers load only on accept so the array stays quiet between jobs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         op_a_q      <= '0;
         op_x_q      <= '0;
         tag_q       <= '0;
         cnt_q       <= '0;
         res_valid_q <= 1'b0;
         res_p_q     <= '0;
         res_id_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (w_found) begin
                  op_a_q  <= w_a_sel;
                  op_x_q  <= w_x_sel;
                  tag_q   <= w_gnt;
                  ptr_q   <= ptr_d;
                  cnt_q   <= C_CNT_INIT;
                  state_q <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (cnt_q == '0) begin
                  res_p_q     <= w_prod;
                  res_id_q    <= tag_q;
                  res_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_DONE: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign res_valid = res_valid_q;
   assign res_p     = res_p_q;
   assign res_id    = res_id_q;
   assign busy      = (state_q != S_IDLE);
endmodule

`default_nettype wire

// File: tb/tb_mult_share_sched.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_mult_share_sched                                         |
// | Purpose  : scoreboard bench for the shared array multiplier scheduler. |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+

module tb_mult_share_sched;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_a = '0;
   logic [31:0] req_x = '0;
   logic [3:0]  req_ready;
   logic        res_valid;
   logic [15:0] res_p;
   logic [1:0]  res_id;
   logic        res_ready = 1'b1;
   logic        busy;

   typedef struct packed {
      logic [1:0]  id;
      logic [15:0] p;
   } exp_t;

   exp_t sbq[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   mult_share_sched #(.M(8), .N(8), .NREQ(4), .SETTLE(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_x     (req_x),
      .req_ready (req_ready),
      .res_valid (res_valid),
      .res_p     (res_p),
      .res_id    (res_id),
      .res_ready (res_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int id, input logic [15:0] p);
      exp_t e;
      e.id = 2'(id);
      e.p  = p;
      sbq.push_back(e);
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!res_valid && n < 40) begin
         step();
         n++;
      end
      if (!res_valid) chk("timeout res_valid", 0, 1);
   endtask

   task automatic do_job(input int k, input logic [7:0] a, input logic [7:0] x);
      logic [15:0] pr;
      int n = 0;
      req_a[k*8 +: 8] = a;
      req_x[k*8 +: 8] = x;
      req_valid = 4'b0001 << k;
      #1;
      while (!req_ready[k] && n < 20) begin
         step();
         n++;
      end
      if (!req_ready[k]) chk("timeout req_ready", 0, 1);
      pr = a * x;
      push(k, pr);
      step();
      req_valid = '0;
      wait_valid();
      step();
   endtask

   // Monitor: every result handshake is matched against the oldest expectation.
   always @(negedge clk) begin
      if (!rst && res_valid && res_ready) begin
         if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected result: id=%0d p=%0d expected none", res_id, res_p);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("res_id", res_id, e.id);
            chk("res_p", res_p, e.p);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int tr [0:4];

      // Reset and idle
      rst = 1'b1;
      repeat (2) step();
      chk("reset outputs", {req_ready, res_valid, res_p, res_id, busy}, 0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("idle outputs", {req_ready, res_valid, res_p, res_id, busy}, 0);
      end

      // Single job from requester 2 with latency checks
      req_a[23:16] = 8'd13;
      req_x[23:16] = 8'd11;
      req_valid    = 4'b0100;
      #1;
      chk("grant single", req_ready, 4'b0100);
      push(2, 16'd143);
      step();
      req_valid = '0;
      chk("busy after accept", busy, 1);
      step();
      chk("valid at T+2", res_valid, 0);
      step();
      chk("valid at T+3", res_valid, 1);
      step();
      chk("busy at T+4", busy, 0);
      req_valid = 4'b0100;
      #1;
      chk("accept at T+4", req_ready, 4'b0100);
      push(2, 16'd143);
      step();
      req_valid = '0;
      wait_valid();
      step();

      // Reset and request together: reset wins
      rst = 1'b1;
      req_valid = 4'b0001;
      step();
      rst = 1'b0;
      req_valid = '0;
      chk("rst beats request", {busy, res_valid}, 0);

      // Round-robin with all four requesters pending
      for (int k = 0; k < 4; k++) begin
         req_a[k*8 +: 8] = 8'(k + 1);
         req_x[k*8 +: 8] = 8'd10;
      end
      push(0, 16'd10);
      push(1, 16'd20);
      push(2, 16'd30);
      push(3, 16'd40);
      push(0, 16'd10);
      req_valid = 4'b1111;
      for (int r = 0; r < 5; r++) begin
         wait_valid();
         tr[r] = cyc;
         if (r == 4) req_valid = '0;
         step();
      end
      for (int r = 1; r < 5; r++) chk("rr spacing", tr[r] - tr[r-1], 4);

      // Back-pressure with the largest operands
      req_a[15:8] = 8'd255;
      req_x[15:8] = 8'd255;
      res_ready   = 1'b0;
      req_valid   = 4'b0010;
      #1;
      chk("grant bp", req_ready, 4'b0010);
      push(1, 16'd65025);
      step();
      req_valid = 4'b1111;
      wait_valid();
      for (int i = 0; i < 7; i++) begin
         chk("stall hold", {res_valid, res_id, res_p}, {1'b1, 2'd1, 16'd65025});
         chk("stall no grant", req_ready, 0);
         step();
      end
      res_ready = 1'b1;
      req_valid = '0;
      step();
      chk("release to idle", {busy, res_valid}, 0);

      // Reset in the middle of a job
      req_a[7:0] = 8'd5;
      req_x[7:0] = 8'd5;
      req_valid  = 4'b0001;
      #1;
      chk("grant before abort", req_ready, 4'b0001);
      step();
      rst = 1'b1;
      req_valid = '0;
      step();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("aborted job silent", {busy, res_valid}, 0);
      end
      req_a[31:24] = 8'd7;
      req_x[31:24] = 8'd9;
      req_valid    = 4'b1001;
      #1;
      chk("ptr reset grant", req_ready, 4'b0001);
      push(0, 16'd25);
      push(3, 16'd63);
      for (int r = 0; r < 2; r++) begin
         wait_valid();
         if (r == 1) req_valid = '0;
         step();
      end

      // Sweep from requester 0
      for (int a = 0; a < 64; a++) begin
         for (int x = 0; x < 64; x++) begin
            do_job(0, 8'(a), 8'(x));
            chk("op_a hold", dut.op_a_q, 64'(a));
            chk("op_x hold", dut.op_x_q, 64'(x));
         end
      end

      repeat (3) step();
      chk("scoreboard drained", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/mult_share_sched.md
# mult_share_sched

Round-robin scheduler that shares one combinational `ArrayMultiplier_generic` instance (M x N array, product M+N bits) among NREQ requesters. It registers the granted operands so the array inputs toggle only when a new product is accepted, and waits a fixed number of settle cycles for the ripple array. It then presents a registered product with the requester ID on a valid/ready result port. It sits between requesting datapath blocks and the shared low-power array multiplier.

## Interface
- `M`, 8, multiplicand width (array `m`)
- `N`, 8, multiplier width (array `n`)
- `NREQ`, 4, number of requesters (2..8)
- `SETTLE`, 2, cycles allowed for array propagation (>= 1)
- `IDW`, `$clog2(NREQ)`, requester ID width (local, derived)

Clock and reset: one clock, `clk`; reset `rst` is synchronous and active-high.

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  NREQ  request valid, one bit per requester
- `req_a`  in  NREQ*M  multiplicands, requester k at [k*M +: M]
- `req_x`  in  NREQ*N  multipliers, requester k at [k*N +: N]
- `req_ready`  out  NREQ  one-hot grant; at most one bit high
- `res_valid`  out  1  product valid
- `res_p`  out  M+N  unsigned product a*x
- `res_id`  out  IDW  index of the requester that owns `res_p`
- `res_ready`  in  1  downstream accepts result
- `busy`  out  1  state != IDLE

## Operation
- FSM states: IDLE, SETTLE, DONE.
- IDLE:
  - Winner g is the first k with `req_valid[k]=1`, scanning ptr, ptr+1, … mod NREQ.
  - `req_ready[g]=1` combinationally; all other ready bits are 0. No valid requests means `req_ready=0`.
- Accept: when `req_valid[g]&req_ready[g]` in IDLE:
  - Load op_a/op_x from slice g and tag register from g.
  - Set ptr <= (g+1) mod NREQ; set cnt <= SETTLE-1; go to SETTLE.
- SETTLE: decrement cnt each cycle. When cnt==0:
  - Capture the array output into `res_p` and the tag into `res_id`.
  - Set `res_valid` <= 1; go to DONE.
- DONE: hold `res_valid`, `res_p` and `res_id` stable until `res_ready=1`, then clear `res_valid` and go to IDLE.
- `req_ready` is 0 in SETTLE and DONE.
- Operand registers change only on accept. They are never cleared by idle or completion (low-power isolation: no array toggling without a new job).
- Arithmetic: unsigned, full-width M+N product, no truncation or saturation. 0*x=0; (2^M-1)*(2^N-1) must be exact.
- Requester inputs are don't-care while that requester's `req_ready=0`; the block ignores them.
- A requester that drops `req_valid` before grant loses nothing. There is no state per requester except the pointer.

## Timing
- Reset values:
  - `req_ready=0`, `res_valid=0`, `res_p=0`, `res_id=0`, `busy=0`.
  - FSM=IDLE, ptr=0, op_a=op_x=0, tag=0, cnt=0.
- Latency: accept handshake in cycle T → `res_valid` first high in cycle T+1+SETTLE (SETTLE=2 → T+3).
- Throughput, with `res_ready` tied high: one product per SETTLE+2 cycles. A new accept is possible in the cycle after the result handshake, never in the same cycle.
- `busy` rises in the cycle after accept and falls in the cycle after the result handshake.
- Fairness: after any grant to k, all other pending requesters are served before k again. Worst-case wait is (NREQ-1)*(SETTLE+2) cycles plus result stalls.
- Back-pressure: DONE may last indefinitely. Outputs stay frozen and no grants are issued.
- Reset in any state: the next cycle matches the reset values. An in-flight job is discarded and no `res_valid` pulse follows.
- Simultaneous `rst` and request: reset wins and no accept occurs.

## Test plan
- Reset/idle:
  - Stimulus: assert `rst` 2 cycles, all `req_valid=0`.
  - Response: all outputs 0, `busy=0`, `req_ready=0` for 10 cycles.
- Single job:
  - Stimulus: requester 2 sends a=8'd13, x=8'd11 at T, `res_ready=1`.
  - Response: `req_ready=4'b0100` at T, `res_valid=1` at T+3 with `res_p=16'd143`, `res_id=2`; next accept possible at T+4.
- Round-robin:
  - Stimulus: all four hold valid continuously with a=k+1, x=10.
  - Response: results appear in order id 0,1,2,3,0 with `res_p` 10,20,30,40,10, spaced 4 cycles apart.
- Back-pressure:
  - Stimulus: a=255, x=255 from requester 1; `res_ready=0` for 7 cycles after `res_valid`.
  - Response: `res_p=16'd65025`, `res_id=1` held stable; `req_ready=0` throughout; release → IDLE next cycle.
- Reset mid-job:
  - Stimulus: accept at T, `rst` at T+1.
  - Response: no `res_valid` ever for that job; ptr=0 so a subsequent request from 0 and 3 simultaneously grants 0 first.
- Exhaustive sweep:
  - Stimulus: requester 0 sweeps a,x over 0..63 each with `res_ready=1`.
  - Response: every `res_p` equals a*x; op registers unchanged (probe) between jobs.
